// File: rtl/loop_ctrl_pkg.sv
// Shared types and helpers for the pipelined loop controller.
package loop_ctrl_pkg;

  localparam int unsigned IDX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of a counter that must hold 0..max; never narrower than one bit.
  function automatic int unsigned phase_w(input int unsigned max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/ii_phase_counter.sv
// Initiation-interval phase counter: counts 0..MAX and wraps, with clear and enable.
module ii_phase_counter
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned MAX = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      en,
  output logic [phase_w(MAX)-1:0]   phase,
  output logic                      at_zero
);

  localparam int unsigned PW = phase_w(MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == PW'(MAX)) ? '0 : phase + PW'(1);
    end
  end

  assign at_zero = (phase == '0);

endmodule

// File: rtl/loop_pipeline_ctrl.sv
// Issues TRIP_COUNT loop iterations every II cycles and tracks them through a
// DEPTH-stage datapath, pulsing done when the last one retires.
module loop_pipeline_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned TRIP_COUNT = 4,
  parameter int unsigned II         = 1,
  parameter int unsigned DEPTH      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  output logic             ready,
  output logic             busy,
  output logic             issue,
  output logic [IDX_W-1:0] iter_idx,
  output logic [DEPTH-1:0] stage_valid,
  output logic             done
);

  localparam int unsigned    PHASE_MAX = II - 1;
  localparam int unsigned    PW        = phase_w(PHASE_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((TRIP_COUNT == 0) ? 0 : TRIP_COUNT - 1);
  localparam logic [DEPTH-1:0] TAIL_ONLY = DEPTH'(1) << (DEPTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic             accept;
  logic             last_issue;
  logic             drain_exit;
  logic             phase_clear;
  logic             phase_en;
  logic             at_zero;
  logic [PW-1:0]    phase;
  logic             unused_phase;
  logic [DEPTH-1:0] sv_shift;
  logic             sv_advance;

  assign accept      = start & (state_q == IDLE) & ~abort;
  assign issue       = (state_q == ISSUE) & at_zero & ~stall;
  assign last_issue  = issue & (iter_idx == LAST_IDX);
  assign drain_exit  = ~stall & (stage_valid == TAIL_ONLY);
  assign ready       = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign unused_phase = ^phase;

  // Phase restarts whenever a run begins or is killed.
  assign phase_clear = abort | accept;
  assign phase_en    = (state_q == ISSUE) & ~stall;

  ii_phase_counter #(
    .MAX (PHASE_MAX)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .clear   (phase_clear),
    .en      (phase_en),
    .phase   (phase),
    .at_zero (at_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (TRIP_COUNT == 0) ? DONE : ISSUE;
        ISSUE:   if (last_issue) state_d = DRAIN;
        DRAIN:   if (drain_exit) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_idx <= '0;
    end else if (accept) begin
      iter_idx <= '0;
    end else if (issue) begin
      iter_idx <= iter_idx + IDX_W'(1);
    end
  end

  generate
    if (DEPTH == 1) begin : g_sv_single
      assign sv_shift = issue;
    end else begin : g_sv_chain
      assign sv_shift = {stage_valid[DEPTH-2:0], issue};
    end
  endgenerate

  // Back-pressure only freezes the pipeline while a run is actually in flight.
  assign sv_advance = ~stall | (state_q == IDLE) | (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= '0;
    end else if (abort) begin
      stage_valid <= '0;
    end else if (sv_advance) begin
      stage_valid <= sv_shift;
    end
  end

endmodule

// File: tb/tb_loop_pipeline_ctrl.sv
// Bench for loop_pipeline_ctrl: four configurations driven in parallel, checked
// against an iteration-age model plus directed timing scenarios.
module tb_loop_pipeline_ctrl;

  localparam int unsigned NCFG = 4;
  localparam int unsigned CFG_N  [NCFG] = '{4, 4, 0, 3};
  localparam int unsigned CFG_II [NCFG] = '{2, 1, 1, 3};
  localparam int unsigned CFG_D  [NCFG] = '{3, 3, 3, 1};
  localparam int unsigned SLOTS = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic stall;

  logic [NCFG-1:0] ready_w;
  logic [NCFG-1:0] busy_w;
  logic [NCFG-1:0] issue_w;
  logic [NCFG-1:0] done_w;
  logic [31:0]     idx_w [NCFG];
  logic [2:0]      sv0;
  logic [2:0]      sv1;
  logic [2:0]      sv2;
  logic            sv3;
  logic [31:0]     sv_w [NCFG];

  always #5 clk = ~clk;

  always_comb begin
    sv_w[0] = 32'(sv0);
    sv_w[1] = 32'(sv1);
    sv_w[2] = 32'(sv2);
    sv_w[3] = 32'(sv3);
  end

  loop_pipeline_ctrl #(.TRIP_COUNT(CFG_N[0]), .II(CFG_II[0]), .DEPTH(CFG_D[0])) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .ready(ready_w[0]), .busy(busy_w[0]), .issue(issue_w[0]), .iter_idx(idx_w[0]),
    .stage_valid(sv0), .done(done_w[0]));

  loop_pipeline_ctrl #(.TRIP_COUNT(CFG_N[1]), .II(CFG_II[1]), .DEPTH(CFG_D[1])) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .ready(ready_w[1]), .busy(busy_w[1]), .issue(issue_w[1]), .iter_idx(idx_w[1]),
    .stage_valid(sv1), .done(done_w[1]));

  loop_pipeline_ctrl #(.TRIP_COUNT(CFG_N[2]), .II(CFG_II[2]), .DEPTH(CFG_D[2])) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .ready(ready_w[2]), .busy(busy_w[2]), .issue(issue_w[2]), .iter_idx(idx_w[2]),
    .stage_valid(sv2), .done(done_w[2]));

  loop_pipeline_ctrl #(.TRIP_COUNT(CFG_N[3]), .II(CFG_II[3]), .DEPTH(CFG_D[3])) u_d (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .ready(ready_w[3]), .busy(busy_w[3]), .issue(issue_w[3]), .iter_idx(idx_w[3]),
    .stage_valid(sv3), .done(done_w[3]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Model: run mode (0 idle, 1 issuing, 2 draining, 3 done pulse), next index,
  // non-stalled cycles until the next launch, and the age of every in-flight iteration.
  int m_mode [NCFG];
  int m_idx  [NCFG];
  int m_wait [NCFG];
  int m_age  [NCFG][SLOTS];

  int cyc;
  int iss_cyc0 [$];
  int iss_idx0 [$];
  int first_done [NCFG];
  logic [NCFG-1:0] rdy_hist [64];
  logic [31:0]     sv0_hist [64];
  logic [31:0]     sv1_hist [64];

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) begin
      m_mode[i] = 0;
      m_idx[i]  = 0;
      m_wait[i] = 0;
      for (int s = 0; s < SLOTS; s++) m_age[i][s] = -1;
    end
  endtask

  function automatic logic [31:0] model_sv(input int i);
    logic [31:0] v = '0;
    for (int s = 0; s < SLOTS; s++)
      if (m_age[i][s] >= 0) v[m_age[i][s]] = 1'b1;
    return v;
  endfunction

  function automatic logic model_issue(input int i, input logic st);
    return (m_mode[i] == 1) && (m_wait[i] == 0) && !st;
  endfunction

  task automatic model_step(input logic s, input logic a, input logic st);
    for (int i = 0; i < NCFG; i++) begin
      logic launch;
      logic adv;
      int   cnt;
      int   tail_only;
      launch = model_issue(i, st);
      if (a) begin
        m_mode[i] = 0;
        m_wait[i] = 0;
        for (int k = 0; k < SLOTS; k++) m_age[i][k] = -1;
        continue;
      end
      cnt = 0;
      tail_only = 1;
      for (int k = 0; k < SLOTS; k++)
        if (m_age[i][k] >= 0) begin
          cnt++;
          if (m_age[i][k] != int'(CFG_D[i]) - 1) tail_only = 0;
        end
      adv = (m_mode[i] == 0) || (m_mode[i] == 3) || !st;
      if (adv)
        for (int k = 0; k < SLOTS; k++)
          if (m_age[i][k] >= 0) begin
            m_age[i][k]++;
            if (m_age[i][k] >= int'(CFG_D[i])) m_age[i][k] = -1;
          end
      if (launch)
        for (int k = 0; k < SLOTS; k++)
          if (m_age[i][k] < 0) begin
            m_age[i][k] = 0;
            break;
          end
      case (m_mode[i])
        0: if (s) begin
             m_idx[i]  = 0;
             m_wait[i] = 0;
             m_mode[i] = (CFG_N[i] > 0) ? 1 : 3;
           end
        1: if (!st) begin
             if (launch) begin
               m_idx[i]++;
               if (m_idx[i] == int'(CFG_N[i])) m_mode[i] = 2;
               else m_wait[i] = int'(CFG_II[i]) - 1;
             end else begin
               m_wait[i]--;
             end
           end
        2: if (!st && cnt > 0 && tail_only != 0) m_mode[i] = 3;
        default: m_mode[i] = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCFG; i++) begin
      logic exp_iss;
      exp_iss = model_issue(i, stall);
      check_eq($sformatf("c%0d cyc%0d ready", i, cyc), 32'(ready_w[i]), 32'(m_mode[i] == 0));
      check_eq($sformatf("c%0d cyc%0d busy", i, cyc), 32'(busy_w[i]), 32'(m_mode[i] != 0));
      check_eq($sformatf("c%0d cyc%0d done", i, cyc), 32'(done_w[i]), 32'(m_mode[i] == 3));
      check_eq($sformatf("c%0d cyc%0d issue", i, cyc), 32'(issue_w[i]), 32'(exp_iss));
      check_eq($sformatf("c%0d cyc%0d stage_valid", i, cyc), sv_w[i], model_sv(i));
      if (exp_iss)
        check_eq($sformatf("c%0d cyc%0d iter_idx", i, cyc), idx_w[i], 32'(m_idx[i]));
      if (done_w[i] && first_done[i] < 0) first_done[i] = cyc;
    end
    if (issue_w[0]) begin
      iss_cyc0.push_back(cyc);
      iss_idx0.push_back(int'(idx_w[0]));
    end
    if (cyc < 64) begin
      rdy_hist[cyc] = ready_w;
      sv0_hist[cyc] = sv_w[0];
      sv1_hist[cyc] = sv_w[1];
    end
  endtask

  task automatic run_cycle(input logic s, input logic a, input logic st);
    start = s;
    abort = a;
    stall = st;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step(s, a, st);
    cyc++;
    #1;
  endtask

  task automatic run_seq(input int ncyc, input int stall_lo, input int stall_hi,
                         input int abort_at, input int start2_at);
    cyc = 0;
    iss_cyc0.delete();
    iss_idx0.delete();
    for (int i = 0; i < NCFG; i++) first_done[i] = -1;
    for (int c = 0; c < ncyc; c++)
      run_cycle(c == 0 || c == start2_at, c == abort_at, c >= stall_lo && c <= stall_hi);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) run_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_issue_log(input string tag, input int c0, input int c1,
                                 input int c2, input int c3);
    int exp_c [4];
    exp_c = '{c0, c1, c2, c3};
    check_eq({tag, " count"}, 32'(iss_cyc0.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s cyc k%0d", tag, k),
               (k < iss_cyc0.size()) ? 32'(iss_cyc0[k]) : 32'hffff_ffff, 32'(exp_c[k]));
      check_eq($sformatf("%s idx k%0d", tag, k),
               (k < iss_idx0.size()) ? 32'(iss_idx0[k]) : 32'hffff_ffff, 32'(k));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " ready"}, 32'(ready_w), 32'hf);
    check_eq({tag, " busy"},  32'(busy_w),  32'h0);
    check_eq({tag, " issue"}, 32'(issue_w), 32'h0);
    check_eq({tag, " done"},  32'(done_w),  32'h0);
    for (int i = 0; i < NCFG; i++) begin
      check_eq($sformatf("%s c%0d stage_valid", tag, i), sv_w[i], 32'h0);
      check_eq($sformatf("%s c%0d iter_idx", tag, i), idx_w[i], 32'h0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    cyc   = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back and II=2 timing, zero trip count, start while busy ignored.
    run_seq(16, -1, -2, -1, 5);
    check_issue_log("t1 issue", 1, 3, 5, 7);
    check_eq("t1 done cycle", 32'(first_done[0]), 32'd11);
    check_eq("t1 ready before done", 32'(rdy_hist[11][0]), 32'd0);
    check_eq("t1 ready after done", 32'(rdy_hist[12][0]), 32'd1);
    check_eq("t2 stage_valid cyc4", sv1_hist[4], 32'h7);
    check_eq("t2 done cycle", 32'(first_done[1]), 32'd8);
    check_eq("t4 done cycle", 32'(first_done[2]), 32'd1);
    check_eq("t4 ready cyc2", 32'(rdy_hist[2][2]), 32'd1);
    check_eq("depth1 done cycle", 32'(first_done[3]), 32'd9);
    idle(4);

    // Stall during cycles 3-4 defers every later launch.
    run_seq(20, 3, 4, -1, -1);
    check_issue_log("t3 issue", 1, 5, 7, 9);
    check_eq("t3 done cycle", 32'(first_done[0]), 32'd13);
    idle(4);

    // Abort mid-run: everything idle next cycle, no done afterwards.
    run_seq(16, -1, -2, 4, -1);
    check_eq("t5 ready cyc5", 32'(rdy_hist[5]), 32'hf);
    check_eq("t5 stage_valid cyc5", sv0_hist[5], 32'h0);
    check_eq("t5 no done c0", 32'(first_done[0]), 32'hffff_ffff);
    check_eq("t5 no done c1", 32'(first_done[1]), 32'hffff_ffff);
    check_eq("t5 no done c3", 32'(first_done[3]), 32'hffff_ffff);
    run_cycle(1'b1, 1'b1, 1'b0);
    check_eq("t5 abort+start ready", 32'(ready_w), 32'hf);
    check_eq("t5 abort+start busy", 32'(busy_w), 32'h0);
    idle(2);

    // Asynchronous reset in the middle of a run, then a clean rerun.
    run_seq(6, -1, -2, -1, -1);
    start = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6 async reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_seq(16, -1, -2, -1, -1);
    check_issue_log("t6 rerun issue", 1, 3, 5, 7);
    check_eq("t6 rerun done cycle", 32'(first_done[0]), 32'd11);
    check_eq("t6 rerun ready", 32'(rdy_hist[12][0]), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++)
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0,
                $urandom_range(0, 3) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
